// File: rtl/rob.sv
// Reorder buffer: allocates entries in program order, accepts out-of-order
// writebacks by id, and offers the oldest completed entry to commit.
module rob #(
    parameter int unsigned ID_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_en_i,
    input  logic [4:0]      alloc_regaddr_i,
    input  logic [31:0]     alloc_pc_i,
    input  logic [1:0]      alloc_branch_tag_i,
    output logic [ID_W-1:0] alloc_id_o,
    output logic            full_o,
    input  logic            wb_en_i,
    input  logic [ID_W-1:0] wb_id_i,
    input  logic [31:0]     wb_data_i,
    input  logic            wb_cond_i,
    output logic            en_o,
    output logic [4:0]      regaddr_o,
    output logic [ID_W-1:0] id_o,
    output logic [31:0]     data_o,
    output logic [31:0]     pc_o,
    output logic [1:0]      branch_tag_o,
    output logic            cond_o,
    input  logic            rdy_i,
    input  logic            rst_c_i
);
    localparam int unsigned DEPTH = 2 ** ID_W;
    localparam int unsigned CNT_W = ID_W + 1;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    logic [4:0]       regaddr_q    [DEPTH];
    logic [31:0]      pc_q         [DEPTH];
    logic [1:0]       branch_tag_q [DEPTH];
    logic [31:0]      data_q       [DEPTH];
    logic             cond_q       [DEPTH];

    logic [ID_W-1:0]  head_q;
    logic [ID_W-1:0]  tail_q;
    logic [CNT_W-1:0] count_q;

    logic alloc_fire_c;
    logic retire_fire_c;
    logic wb_fire_c;

    // Head presentation is purely a function of registered state
    always_comb begin
        full_o        = (count_q == CNT_W'(DEPTH));
        en_o          = valid_q[head_q] && done_q[head_q];
        alloc_id_o    = tail_q;
        id_o          = head_q;
        regaddr_o     = '0;
        data_o        = '0;
        pc_o          = '0;
        branch_tag_o  = '0;
        cond_o        = 1'b0;
        if (en_o) begin
            regaddr_o    = regaddr_q[head_q];
            data_o       = data_q[head_q];
            pc_o         = pc_q[head_q];
            branch_tag_o = branch_tag_q[head_q];
            cond_o       = cond_q[head_q];
        end
        alloc_fire_c  = alloc_en_i && !full_o;
        retire_fire_c = rdy_i && en_o;
        wb_fire_c     = wb_en_i && valid_q[wb_id_i];
    end

    // Control state; flush outranks every other update in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rst_c_i) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (wb_fire_c) begin
                done_q[wb_id_i] <= 1'b1;
            end
            if (retire_fire_c) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + ID_W'(1);
            end
            if (alloc_fire_c) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + ID_W'(1);
            end
            if (alloc_fire_c && !retire_fire_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!alloc_fire_c && retire_fire_c) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Payload storage; stale contents are masked by valid/done
    always_ff @(posedge clk) begin
        if (alloc_fire_c && !rst_c_i) begin
            regaddr_q[tail_q]    <= alloc_regaddr_i;
            pc_q[tail_q]         <= alloc_pc_i;
            branch_tag_q[tail_q] <= alloc_branch_tag_i;
        end
        if (wb_fire_c && !rst_c_i) begin
            data_q[wb_id_i] <= wb_data_i;
            cond_q[wb_id_i] <= wb_cond_i;
        end
    end
endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: reset, out-of-order completion, full, flush,
// simultaneous allocate/retire and invalid writeback.
module tb_rob;
    logic        clk;
    logic        rst;
    logic        alloc_en_i;
    logic [4:0]  alloc_regaddr_i;
    logic [31:0] alloc_pc_i;
    logic [1:0]  alloc_branch_tag_i;
    logic [4:0]  alloc_id_o;
    logic        full_o;
    logic        wb_en_i;
    logic [4:0]  wb_id_i;
    logic [31:0] wb_data_i;
    logic        wb_cond_i;
    logic        en_o;
    logic [4:0]  regaddr_o;
    logic [4:0]  id_o;
    logic [31:0] data_o;
    logic [31:0] pc_o;
    logic [1:0]  branch_tag_o;
    logic        cond_o;
    logic        rdy_i;
    logic        rst_c_i;

    int total = 0;
    int bad   = 0;

    rob #(.ID_W(5)) dut (
        .clk(clk), .rst(rst),
        .alloc_en_i(alloc_en_i), .alloc_regaddr_i(alloc_regaddr_i),
        .alloc_pc_i(alloc_pc_i), .alloc_branch_tag_i(alloc_branch_tag_i),
        .alloc_id_o(alloc_id_o), .full_o(full_o),
        .wb_en_i(wb_en_i), .wb_id_i(wb_id_i), .wb_data_i(wb_data_i),
        .wb_cond_i(wb_cond_i),
        .en_o(en_o), .regaddr_o(regaddr_o), .id_o(id_o), .data_o(data_o),
        .pc_o(pc_o), .branch_tag_o(branch_tag_o), .cond_o(cond_o),
        .rdy_i(rdy_i), .rst_c_i(rst_c_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_en_i = 1'b0; alloc_regaddr_i = '0; alloc_pc_i = '0; alloc_branch_tag_i = '0;
        wb_en_i = 1'b0; wb_id_i = '0; wb_data_i = '0; wb_cond_i = 1'b0;
        rdy_i = 1'b0; rst_c_i = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] ra, input logic [31:0] pc, input logic [1:0] tag);
        alloc_en_i = 1'b1; alloc_regaddr_i = ra; alloc_pc_i = pc; alloc_branch_tag_i = tag;
        tick();
        alloc_en_i = 1'b0;
    endtask

    task automatic wb(input logic [4:0] id, input logic [31:0] d, input logic c);
        wb_en_i = 1'b1; wb_id_i = id; wb_data_i = d; wb_cond_i = c;
        tick();
        wb_en_i = 1'b0;
    endtask

    // Asynchronous reset pulse placed mid-cycle
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1;
        chk("reset_en", 32'(en_o), 32'd0);
        chk("reset_full", 32'(full_o), 32'd0);
        chk("reset_alloc_id", 32'(alloc_id_o), 32'd0);
        chk("reset_data", data_o, 32'd0);
        #1 rst = 1'b0;
        tick();

        // Out-of-order writeback, in-order commit
        alloc_en_i = 1'b1; alloc_regaddr_i = 5'd3;
        chk("ooo_first_id", 32'(alloc_id_o), 32'd0);
        tick();
        alloc_regaddr_i = 5'd4; tick();
        alloc_regaddr_i = 5'd5; tick();
        alloc_en_i = 1'b0;
        chk("ooo_tail", 32'(alloc_id_o), 32'd3);
        chk("ooo_no_done", 32'(en_o), 32'd0);
        wb(5'd2, 32'hA, 1'b0);
        chk("ooo_young_done_hidden", 32'(en_o), 32'd0);
        wb(5'd0, 32'hB, 1'b0);
        wb_en_i = 1'b1; wb_id_i = 5'd1; wb_data_i = 32'hC; rdy_i = 1'b1;
        chk("ooo_c0_en", 32'(en_o), 32'd1);
        chk("ooo_c0_id", 32'(id_o), 32'd0);
        chk("ooo_c0_reg", 32'(regaddr_o), 32'd3);
        chk("ooo_c0_data", data_o, 32'hB);
        tick();
        wb_en_i = 1'b0;
        chk("ooo_c1_en", 32'(en_o), 32'd1);
        chk("ooo_c1_id", 32'(id_o), 32'd1);
        chk("ooo_c1_reg", 32'(regaddr_o), 32'd4);
        chk("ooo_c1_data", data_o, 32'hC);
        tick();
        chk("ooo_c2_id", 32'(id_o), 32'd2);
        chk("ooo_c2_reg", 32'(regaddr_o), 32'd5);
        chk("ooo_c2_data", data_o, 32'hA);
        tick();
        rdy_i = 1'b0;
        chk("ooo_drained_en", 32'(en_o), 32'd0);
        chk("ooo_drained_cnt", 32'(dut.count_q), 32'd0);

        // Reset with five live entries, head completed
        for (int i = 0; i < 5; i++) alloc(5'(i + 10), 32'(i), 2'b00);
        wb(5'd3, 32'h1234, 1'b1);
        chk("pre_reset_en", 32'(en_o), 32'd1);
        chk("pre_reset_data", data_o, 32'h1234);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_en", 32'(en_o), 32'd0);
        chk("async_rst_data", data_o, 32'd0);
        chk("async_rst_reg", 32'(regaddr_o), 32'd0);
        chk("async_rst_alloc_id", 32'(alloc_id_o), 32'd0);
        chk("async_rst_full", 32'(full_o), 32'd0);
        #1 rst = 1'b0;
        tick();

        // Fill to 32 entries, drop the 33rd, then alloc+retire while full
        for (int i = 0; i < 31; i++) alloc(5'(i), 32'(i), 2'b00);
        chk("full_at_31", 32'(full_o), 32'd0);
        alloc(5'd31, 32'd31, 2'b00);
        chk("full_at_32", 32'(full_o), 32'd1);
        chk("full_tail_wrap", 32'(alloc_id_o), 32'd0);
        alloc(5'd7, 32'd7, 2'b00);
        chk("full_drop_tail", 32'(alloc_id_o), 32'd0);
        chk("full_drop_cnt", 32'(dut.count_q), 32'd32);
        wb(5'd0, 32'h55, 1'b0);
        chk("full_head_en", 32'(en_o), 32'd1);
        chk("full_head_data", data_o, 32'h55);
        alloc_en_i = 1'b1; alloc_regaddr_i = 5'd8; rdy_i = 1'b1;
        tick();
        alloc_en_i = 1'b0; rdy_i = 1'b0;
        chk("full_retire_full", 32'(full_o), 32'd0);
        chk("full_retire_alloc_rejected", 32'(alloc_id_o), 32'd0);
        chk("full_retire_head", 32'(id_o), 32'd1);
        alloc(5'd9, 32'd9, 2'b00);
        chk("full_realloc_full", 32'(full_o), 32'd1);
        chk("full_realloc_tail", 32'(alloc_id_o), 32'd1);
        mid_reset();
        tick();

        // Alloc and retire in one cycle at count 4
        for (int i = 0; i < 4; i++) alloc(5'(i + 1), 32'(i), 2'b00);
        wb(5'd0, 32'h10, 1'b0);
        wb(5'd1, 32'h11, 1'b0);
        chk("sim_cnt_before", 32'(dut.count_q), 32'd4);
        alloc_en_i = 1'b1; alloc_regaddr_i = 5'd20; rdy_i = 1'b1;
        tick();
        alloc_en_i = 1'b0;
        chk("sim_cnt_after", 32'(dut.count_q), 32'd4);
        chk("sim_head", 32'(id_o), 32'd1);
        chk("sim_tail", 32'(alloc_id_o), 32'd5);
        chk("sim_en_done", 32'(en_o), 32'd1);
        chk("sim_data", data_o, 32'h11);
        tick();
        rdy_i = 1'b0;
        chk("sim_en_not_done", 32'(en_o), 32'd0);
        chk("sim_head2", 32'(id_o), 32'd2);
        mid_reset();
        tick();

        // Mispredict flush with younger entries and same-cycle alloc/writeback
        alloc(5'd7, 32'h100, 2'b01);
        for (int i = 0; i < 3; i++) alloc(5'(i + 8), 32'(i + 200), 2'b00);
        wb(5'd0, 32'h1, 1'b0);
        for (int i = 1; i < 4; i++) wb(5'(i), 32'(i + 64), 1'b1);
        chk("br_en", 32'(en_o), 32'd1);
        chk("br_pc", pc_o, 32'h100);
        chk("br_tag", 32'(branch_tag_o), 32'd1);
        chk("br_cond", 32'(cond_o), 32'd0);
        chk("br_reg", 32'(regaddr_o), 32'd7);
        rdy_i = 1'b1; rst_c_i = 1'b1;
        alloc_en_i = 1'b1; alloc_regaddr_i = 5'd30;
        wb_en_i = 1'b1; wb_id_i = 5'd4; wb_data_i = 32'hDEAD;
        tick();
        idle();
        chk("flush_cnt", 32'(dut.count_q), 32'd0);
        chk("flush_en", 32'(en_o), 32'd0);
        chk("flush_alloc_id", 32'(alloc_id_o), 32'd0);
        chk("flush_full", 32'(full_o), 32'd0);
        alloc(5'd12, 32'd0, 2'b00);
        chk("post_flush_en", 32'(en_o), 32'd0);
        chk("post_flush_tail", 32'(alloc_id_o), 32'd1);

        // Writeback to an id that was never allocated
        wb(5'd20, 32'hBEEF, 1'b1);
        chk("inv_wb_en", 32'(en_o), 32'd0);
        chk("inv_wb_cnt", 32'(dut.count_q), 32'd1);
        chk("inv_wb_valid", 32'(dut.valid_q[20]), 32'd0);
        wb(5'd0, 32'h77, 1'b0);
        chk("valid_wb_en", 32'(en_o), 32'd1);
        chk("valid_wb_data", data_o, 32'h77);
        chk("valid_wb_reg", 32'(regaddr_o), 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rob.md
# rob

Reorder buffer that feeds the in-order commit stage. Dispatch allocates entries in program order. Execution units write results back out of order, tagged by entry id. The oldest completed entry is presented to commit each cycle, and a commit-issued flush clears all in-flight state after a branch mispredict.

## Interface
- ID_W, 5, entry id width; depth is 2**ID_W (32 entries)
- clk  input  1  clock, all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- alloc_en_i  input  1  dispatch requests one entry this cycle
- alloc_regaddr_i  input  5  destination architectural register
- alloc_pc_i  input  32  redirect PC, used if this branch mispredicts
- alloc_branch_tag_i  input  2  00 non-branch, 01 predicted taken, 10 predicted not-taken
- alloc_id_o  output  ID_W  id the entry receives if allocated this cycle (current tail)
- full_o  output  1  all entries occupied
- wb_en_i  input  1  result writeback valid
- wb_id_i  input  ID_W  entry being completed
- wb_data_i  input  32  result value
- wb_cond_i  input  1  resolved branch condition (1 = taken)
- en_o  output  1  head entry valid and completed, offered to commit
- regaddr_o  output  5  head destination register
- id_o  output  ID_W  head entry id
- data_o  output  32  head result
- pc_o  output  32  head redirect PC
- branch_tag_o  output  2  head branch tag
- cond_o  output  1  head resolved condition
- rdy_i  input  1  commit accepted the head this cycle
- rst_c_i  input  1  commit flush request (mispredict)

## Operation
- Per-entry storage: valid, done, regaddr, pc, branch_tag, data, cond. Pointers head, tail (ID_W bits each) and a count (ID_W+1 bits).
- Allocate: when alloc_en_i && !full_o, store fields at tail, set valid=1 and done=0, then tail+1 (mod 2**ID_W) and count+1. When alloc_en_i is asserted with full_o high, the request is dropped with no state change. Dispatch must stall on full_o.
- Writeback: when wb_en_i is asserted and entry wb_id_i is valid, store data and cond and set done=1. A writeback to an invalid entry is ignored.
- Head presentation is combinational from registered state. en_o = valid[head] && done[head]. Field outputs come from the head entry when en_o=1 and are 0 otherwise. id_o = head.
- Retire: when rdy_i && en_o, clear valid[head], then head+1 and count-1. rdy_i while en_o=0 is ignored.
- Allocate and retire in the same cycle: both happen and count is unchanged. full_o is computed from count before the edge. A full buffer therefore rejects the allocation even when the head retires in the same cycle.
- Flush: rst_c_i arrives in the same cycle as the mispredicting branch's rdy_i. At the edge:
  - all valid and done bits clear;
  - head = tail = count = 0;
  - any alloc or writeback in that cycle is discarded.
  The branch's own register write still happens, because commit performs it combinationally that cycle.
- Flush has priority over alloc, writeback and retire in the same cycle.
- The buffer has no knowledge of x0. Entries with regaddr 0 retire normally.

## Timing
- Reset (asynchronous, immediate): head = tail = count = 0 and all valid/done bits clear. Resulting outputs: en_o=0, all head fields 0, alloc_id_o=0, full_o=0.
- Latency:
  - allocation at edge N is visible in storage after edge N;
  - writeback at edge M makes en_o rise in cycle M+1 if the entry is at head;
  - there is no same-cycle bypass from writeback to en_o.
- Minimum allocate-to-commit: alloc at edge N, writeback in cycle N+1 (edge N+1), en_o high in cycle N+2.
- Throughput: one allocate, one writeback and one retire per cycle.
- Wrap-around: pointers wrap modulo 32. Ids are reused after retirement. full_o = (count == 32).
- Reset asserted mid-operation discards all entries. Nothing is offered to commit until new allocation and writeback occur.

## Test plan
- Reset: assert rst mid-cycle with 5 entries live -> en_o, full_o, alloc_id_o and all head fields drop to 0 immediately; after release the first allocation gets id 0.
- Out-of-order writeback: allocate ids 0,1,2 (regaddr 3,4,5); write back 2, then 0, then 1 with data 0xA, 0xB, 0xC in consecutive cycles; hold rdy_i=en_o -> commits in order id 0/reg 3/0xB, id 1/reg 4/0xC, id 2/reg 5/0xA.
- Full: allocate 32 entries -> full_o=1; a 33rd alloc_en_i is dropped and tail stays 0; retire one -> full_o=0 and the next allocation gets id 0.
- Mispredict flush: allocate a branch with tag 01 and pc 0x100, plus 3 younger entries; write back all with the branch cond 0; pulse rst_c_i with rdy_i at the branch -> next cycle count=0, en_o=0, alloc_id_o=0, and a same-cycle alloc or writeback has no effect.
- Simultaneous allocate and retire at count 4 -> count stays 4, head and tail both advance, and en_o follows the new head's done bit.
- Writeback to an invalid id (never allocated) -> no entry changes and en_o stays 0.
